// File: rtl/sm_stream_accumulator.sv
// Streaming sign-magnitude frame accumulator: a registered lane-sum stage, an accumulate/clamp stage,
// a result stage and a held output register, with valid/ready on both sides.
module sm_stream_accumulator #(
    parameter int WIDTH     = 9,
    parameter int LANES     = 4,
    parameter int ACC_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [LANES*WIDTH-1:0] in_data,
    input  logic                   in_valid,
    input  logic                   in_last,
    output logic                   in_ready,
    output logic [ACC_WIDTH-1:0]   out_data,
    output logic                   out_sat,
    output logic                   out_valid,
    input  logic                   out_ready
);

    localparam int LSW  = WIDTH + $clog2(LANES) + 1;
    localparam int NW   = ((ACC_WIDTH > LSW) ? ACC_WIDTH : LSW) + 1;
    localparam int MAGW = ACC_WIDTH - 1;
    localparam logic signed [NW-1:0] MAXV = {{(NW-MAGW){1'b0}}, {MAGW{1'b1}}};
    localparam logic signed [NW-1:0] MINV = -MAXV;

    logic                        stall;
    logic                        accept;
    logic signed [LSW-1:0]       lane_sum;

    logic                        s1_valid;
    logic                        s1_last;
    logic signed [LSW-1:0]       s1_sum;

    logic signed [ACC_WIDTH-1:0] acc;
    logic                        sat;
    logic signed [NW-1:0]        acc_sum;
    logic signed [NW-1:0]        acc_wide;
    logic signed [ACC_WIDTH-1:0] acc_clamped;
    logic                        clamp;
    logic [ACC_WIDTH-1:0]        sm_result;

    logic                        s2_valid;
    logic [ACC_WIDTH-1:0]        s2_data;
    logic                        s2_sat;

    assign stall    = out_valid & ~out_ready;
    assign in_ready = ~rst & ~stall;
    assign accept   = in_valid & in_ready;

    // Negative zero needs no special case: a zero magnitude subtracts nothing.
    always_comb begin
        lane_sum = '0;
        for (int unsigned k = 0; k < LANES; k++) begin
            if (in_data[k*WIDTH + WIDTH - 1])
                lane_sum = lane_sum - LSW'(in_data[k*WIDTH +: WIDTH-1]);
            else
                lane_sum = lane_sum + LSW'(in_data[k*WIDTH +: WIDTH-1]);
        end
    end

    always_comb begin
        acc_sum  = NW'(acc) + NW'(s1_sum);
        acc_wide = acc_sum;
        clamp    = 1'b0;
        if (acc_sum > MAXV) begin
            acc_wide = MAXV;
            clamp    = 1'b1;
        end else if (acc_sum < MINV) begin
            acc_wide = MINV;
            clamp    = 1'b1;
        end
        acc_clamped = ACC_WIDTH'(acc_wide);
        // MINV is symmetric, so a negative value always has a nonzero magnitude.
        if (acc_clamped[ACC_WIDTH-1])
            sm_result = {1'b1, MAGW'(-acc_clamped)};
        else
            sm_result = {1'b0, MAGW'(acc_clamped)};
    end

    // The result stage between accumulate and output gives the two-edge last-beat latency
    // while still clearing the accumulator on the last beat for a bubble-free next frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_last   <= 1'b0;
            s1_sum    <= '0;
            acc       <= '0;
            sat       <= 1'b0;
            s2_valid  <= 1'b0;
            s2_data   <= '0;
            s2_sat    <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sat   <= 1'b0;
        end else if (!stall) begin
            s1_valid <= accept;
            if (accept) begin
                s1_sum  <= lane_sum;
                s1_last <= in_last;
            end
            s2_valid <= s1_valid & s1_last;
            if (s1_valid) begin
                if (s1_last) begin
                    acc     <= '0;
                    sat     <= 1'b0;
                    s2_data <= sm_result;
                    s2_sat  <= sat | clamp;
                end else begin
                    acc <= acc_clamped;
                    sat <= sat | clamp;
                end
            end
            out_valid <= s2_valid;
            if (s2_valid) begin
                out_data <= s2_data;
                out_sat  <= s2_sat;
            end
        end
    end

endmodule
